cola_dispenser: RTL
===================

COLA_DISPENSER -- requirements
Module: cola_dispenser

Interface
REQ-001 Parameter PRICE, default 5, price in 0.5-yuan units (5 = 2.5 yuan).
REQ-002 Parameter ACK_TIMEOUT, default 50_000_000, max cycles waiting on any ack edge.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 vend_valid  input  1  one-cycle pulse: coin FSM reached or passed price.
REQ-006 credit  input  3  total inserted, 0.5-yuan units, sampled when vend_valid=1.
REQ-007 cola_req  output  1  four-phase request to cola hopper.
REQ-008 cola_ack  input  1  cola hopper acknowledge, already synchronous to clk.
REQ-009 chg_req  output  1  four-phase request to change hopper, one 0.5-yuan coin per handshake.
REQ-010 chg_ack  input  1  change hopper acknowledge, already synchronous to clk.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when vend completes normally.
REQ-013 reject  output  1  one-cycle pulse when vend_valid arrives with credit < PRICE.
REQ-014 err  output  1  sticky; set on timeout or on overrun; cleared only by rst.
REQ-015 led  output  8  status: led[7:4] = change coins remaining, led[3:0] = one-hot state group.

Function
REQ-016 States: IDLE, COLA_REQ, COLA_REL, CHG_REQ, CHG_REL, FAULT.
REQ-017 IDLE: when vend_valid=1 and credit>=PRICE, latch chg_cnt = credit-PRICE (3-bit, no wrap because credit>=PRICE) and go to COLA_REQ the next cycle.
REQ-018 IDLE: when vend_valid=1 and credit<PRICE, pulse reject the next cycle and stay in IDLE.
REQ-019 COLA_REQ: cola_req=1; on cola_ack=1 go to COLA_REL.
REQ-020 COLA_REL: cola_req=0; on cola_ack=0 go to CHG_REQ if chg_cnt>0, else IDLE with done pulsed.
REQ-021 CHG_REQ: chg_req=1; on chg_ack=1 decrement chg_cnt and go to CHG_REL.
REQ-022 CHG_REL: chg_req=0; on chg_ack=0 go to CHG_REQ if chg_cnt>0, else IDLE with done pulsed.
REQ-023 req outputs are registered; req rises one cycle after entry to its REQ state; no req is asserted while its ack is still high.
REQ-024 vend_valid while busy=1 is dropped, sets err (overrun), and does not disturb the current vend.
REQ-025 vend_valid arriving in the same cycle that done is pulsed is treated as arriving while busy (dropped, overrun).
REQ-026 Only one of cola_req and chg_req is ever high.
REQ-027 led[3:0]: 0001 IDLE, 0010 cola phase, 0100 change phase, 1000 FAULT; led[7:4] = {1'b0, chg_cnt}.

Reset
REQ-028 rst=1 forces IDLE, cola_req=0, chg_req=0, busy=0, done=0, reject=0, err=0, chg_cnt=0, led=8'b0000_0001 on the next edge, including mid-handshake.
REQ-029 After rst is released, the block ignores vend_valid only in the cycle rst is high.

Configuration
REQ-030 Macro COLA_DISPENSER_TIMEOUT_EN defined: a timer counts cycles in each REQ/REL state, resets on every state change, and on reaching ACK_TIMEOUT enters FAULT with both reqs low and err set. FAULT exits only by rst.
REQ-031 Macro not defined: no timer and no FAULT entry; handshakes wait indefinitely; err reflects overrun only.

Structure
REQ-032 Shared package cola_pkg holds the state encodings, the PRICE default, and the 0.5-yuan unit width (3); the coin-acceptor FSM uses the same package.
REQ-033 One sub-module, hs_4phase, implements one req/ack four-phase handshake (start, req, ack, complete) and is instantiated twice (cola, change).

Verification
REQ-034 credit=5, vend_valid pulse, ack hopper after 3 cycles -> one cola handshake, zero chg_req, done pulses once, busy low afterwards.
REQ-035 credit=6 -> one cola handshake followed by exactly one chg handshake; led[7:4] goes 1 to 0; done pulses once.
REQ-036 credit=7, PRICE=4 -> three chg handshakes; chg_req is never high while chg_ack is high.
REQ-037 credit=3 -> reject pulses one cycle later; busy stays 0; no req is asserted.
REQ-038 Second vend_valid during COLA_REQ -> err=1; the first vend completes unchanged; only one done pulse.
REQ-039 TIMEOUT_EN, ACK_TIMEOUT=20, cola_ack held 0 -> FAULT at cycle 20, cola_req=0, err=1, led[3:0]=1000; rst pulse -> IDLE, err=0.

Source files
------------

// File: rtl/cola_pkg.sv
// Shared definitions for the vending slice: FSM state encodings, default price
// and the width of a 0.5-yuan coin count. Also used by the coin-acceptor FSM.
package cola_pkg;

    localparam int UNIT_W        = 3;
    localparam int PRICE_DEFAULT = 5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_COLA_REQ = 3'd1,
        S_COLA_REL = 3'd2,
        S_CHG_REQ  = 3'd3,
        S_CHG_REL  = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    // One-hot status group shown on the low half of the LED bank.
    function automatic logic [3:0] state_group(input state_t s);
        case (s)
            S_IDLE:                 return 4'b0001;
            S_COLA_REQ, S_COLA_REL: return 4'b0010;
            S_CHG_REQ, S_CHG_REL:   return 4'b0100;
            default:                return 4'b1000;
        endcase
    endfunction

endpackage

// File: rtl/hs_4phase.sv
// One four-phase req/ack handshake. The request is registered and is never
// raised while ack is still high, so a stale ack cannot complete a new cycle.
module hs_4phase (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic acked,
    output logic complete
);

    always_ff @(posedge clk) begin
        if (rst) begin
            req <= 1'b0;
        end else begin
            req <= start && !ack;
        end
    end

    assign acked    = req && ack;
    assign complete = !req && !ack;

endmodule

// File: rtl/cola_dispenser.sv
// Vend sequencer: one cola handshake, then one change handshake per 0.5-yuan coin.
// Optional ack watchdog with FAULT state is enabled by COLA_DISPENSER_TIMEOUT_EN.
module cola_dispenser
    import cola_pkg::*;
#(
    parameter int PRICE       = PRICE_DEFAULT,
    parameter int ACK_TIMEOUT = 50_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vend_valid,
    input  logic [UNIT_W-1:0] credit,
    output logic              cola_req,
    input  logic              cola_ack,
    output logic              chg_req,
    input  logic              chg_ack,
    output logic              busy,
    output logic              done,
    output logic              reject,
    output logic              err,
    output logic [7:0]        led
);

    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("ACK_TIMEOUT must be at least 1");
    end

    state_t            state;
    logic [UNIT_W-1:0] chg_cnt;
    logic              timeout_hit;
    logic              cola_acked;
    logic              cola_complete;
    logic              chg_acked;
    logic              chg_complete;
    logic              credit_ok;

    assign credit_ok = int'(credit) >= PRICE;

    hs_4phase u_cola_hs (
        .clk      (clk),
        .rst      (rst),
        .start    ((state == S_COLA_REQ) && !timeout_hit),
        .ack      (cola_ack),
        .req      (cola_req),
        .acked    (cola_acked),
        .complete (cola_complete)
    );

    hs_4phase u_chg_hs (
        .clk      (clk),
        .rst      (rst),
        .start    ((state == S_CHG_REQ) && !timeout_hit),
        .ack      (chg_ack),
        .req      (chg_req),
        .acked    (chg_acked),
        .complete (chg_complete)
    );

`ifdef COLA_DISPENSER_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic          advance;
    logic          in_hs;

    assign in_hs = (state == S_COLA_REQ) || (state == S_COLA_REL) ||
                   (state == S_CHG_REQ)  || (state == S_CHG_REL);

    always_comb begin
        advance = 1'b0;
        case (state)
            S_COLA_REQ: advance = cola_acked;
            S_COLA_REL: advance = cola_complete;
            S_CHG_REQ:  advance = chg_acked;
            S_CHG_REL:  advance = chg_complete;
            default:    advance = 1'b0;
        endcase
    end

    // The timer restarts on every state change, so each phase gets its own budget.
    always_ff @(posedge clk) begin
        if (rst || !in_hs || advance) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign timeout_hit = in_hs && !advance && (timer == TW'(ACK_TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            chg_cnt <= '0;
            done    <= 1'b0;
            reject  <= 1'b0;
            err     <= 1'b0;
        end else begin
            done   <= 1'b0;
            reject <= 1'b0;
            // A request in the completion cycle still counts as overlapping the vend.
            if (vend_valid && (state != S_IDLE || done)) begin
                err <= 1'b1;
            end
            if (timeout_hit) begin
                state <= S_FAULT;
                err   <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (vend_valid && !done) begin
                            if (credit_ok) begin
                                chg_cnt <= credit - UNIT_W'(PRICE);
                                state   <= S_COLA_REQ;
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end
                    S_COLA_REQ: begin
                        if (cola_acked) state <= S_COLA_REL;
                    end
                    S_COLA_REL: begin
                        if (cola_complete) begin
                            if (chg_cnt != '0) begin
                                state <= S_CHG_REQ;
                            end else begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    S_CHG_REQ: begin
                        if (chg_acked) begin
                            chg_cnt <= chg_cnt - 1'b1;
                            state   <= S_CHG_REL;
                        end
                    end
                    S_CHG_REL: begin
                        if (chg_complete) begin
                            if (chg_cnt != '0) begin
                                state <= S_CHG_REQ;
                            end else begin
                                state <= S_IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= S_FAULT;
                endcase
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign led  = {1'b0, chg_cnt, state_group(state)};

endmodule
